// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes and controller FSM state encodings.
//   ALU_AND..ALU_SHL : 3-bit op codes understood by alu_core
//   state_t          : controller FSM states S_IDLE / S_EXEC / S_DONE
package alu_pkg;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_XNOR = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SHL  = 3'b111;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational 8-op 32-bit ALU.
//   op  in  3      op code (alu_pkg ALU_*)
//   a   in  WIDTH  operand A (shift amount for SHL)
//   b   in  WIDTH  operand B (shifted value for SHL)
//   f   out WIDTH  result
//   of  out 1      signed overflow, ADD/SUB only
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] f,
  output logic             of
);
  always_comb begin
    f  = '0;
    of = 1'b0;
    case (op)
      ALU_AND:  f = a & b;
      ALU_OR:   f = a | b;
      ALU_XOR:  f = a ^ b;
      ALU_XNOR: f = ~(a ^ b);
      ALU_ADD: begin
        f  = a + b;
        of = (a[WIDTH-1] == b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        f  = a - b;
        of = (a[WIDTH-1] != b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLTU: f = {{(WIDTH-1){1'b0}}, a < b};
      // Any shift amount of 32 or more empties the word.
      ALU_SHL:  f = (|a[WIDTH-1:5]) ? '0 : b << a[4:0];
    endcase
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU between two requesters; arbitrates, latches
// operands, executes in one cycle and holds a tagged result until consumed.
//   clk, rst_n                 clock, asynchronous active-low reset
//   rN_valid/rN_ready          requester N command handshake (N = 0, 1)
//   rN_op, rN_a, rN_b          requester N op code and operands
//   res_valid/res_ready        result handshake
//   res_f, res_zf, res_of      result, zero flag, signed overflow flag
//   res_id                     requester that issued the result
//   busy                       controller not idle
//   op_cnt                     completed results, wraps
// Config macro ALU_SHARE_RR_EN: defined -> round-robin tie break;
// undefined -> fixed priority, requester 0 wins ties.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [2:0]       r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [2:0]       r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_f,
  output logic             res_zf,
  output logic             res_of,
  output logic             res_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);
  state_t           state, nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, alu_f;
  logic             alu_of, gnt1, accept;
`ifdef ALU_SHARE_RR_EN
  logic ptr;
  // ptr names the requester that wins the next tie; it hands over after every grant.
  assign gnt1 = r1_valid && (!r0_valid || ptr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (accept) ptr <= !gnt1;
`else
  assign gnt1 = r1_valid && !r0_valid;
`endif
  assign accept    = (state == S_IDLE) && (r0_valid || r1_valid);
  assign r0_ready  = accept && !gnt1;
  assign r1_ready  = accept && gnt1;
  assign res_valid = state == S_DONE;
  assign busy      = state != S_IDLE;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = accept ? S_EXEC : S_IDLE;
      S_EXEC:  nxt = S_DONE;
      S_DONE:  nxt = res_ready ? S_IDLE : S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op(op_q),
    .a (a_q),
    .b (b_q),
    .f (alu_f),
    .of(alu_of)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= ALU_AND;
      a_q    <= '0;
      b_q    <= '0;
      res_id <= 1'b0;
      res_f  <= '0;
      res_zf <= 1'b0;
      res_of <= 1'b0;
      op_cnt <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        op_q   <= gnt1 ? r1_op : r0_op;
        a_q    <= gnt1 ? r1_a : r0_a;
        b_q    <= gnt1 ? r1_b : r0_b;
        res_id <= gnt1;
      end
      // Flags are captured with F so they cannot glitch while the result is held.
      if (state == S_EXEC) begin
        res_f  <= alu_f;
        res_zf <= alu_f == '0;
        res_of <= alu_of;
      end
      if (state == S_DONE && res_ready) op_cnt <= op_cnt + 1'b1;
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: scoreboard bench for alu_share_ctrl (CNT_W = 4 so the counter wraps quickly).
module tb_alu_share_ctrl;
  localparam int CW = 4;
`ifdef ALU_SHARE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic r0_valid = 0, r1_valid = 0, res_ready = 0;
  logic [2:0] r0_op = 0, r1_op = 0;
  logic [31:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0;
  logic r0_ready, r1_ready, res_valid, res_zf, res_of, res_id, busy;
  logic [31:0] res_f;
  logic [CW-1:0] op_cnt;
  always #5 clk = ~clk;
  alu_share_ctrl #(.WIDTH(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_f(res_f), .res_zf(res_zf),
    .res_of(res_of), .res_id(res_id), .busy(busy), .op_cnt(op_cnt)
  );
  typedef struct {
    logic [31:0] f;
    logic        zf;
    logic        of;
    logic        id;
    int          acc;
  } exp_t;
  exp_t q[$];
  int grants[$];
  int vectors = 0, errs = 0, cyc = 0;
  logic ptr_m = 1'b0;
  logic [CW-1:0] cnt_m = '0;
  logic prev_v = 1'b0;
  logic sv[2], so[2];
  logic [2:0] sop[2];
  logic [31:0] sa[2], sb[2];
  exp_t sx[2];
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask
  // Reference: results from plain integer arithmetic on the op definitions.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint s;
    e.f = 0;
    e.of = 0;
    e.id = 0;
    e.acc = 0;
    case (op)
      3'd0: e.f = a & b;
      3'd1: e.f = a | b;
      3'd2: e.f = a ^ b;
      3'd3: e.f = ~(a ^ b);
      3'd4, 3'd5: begin
        s = (op == 3'd4) ? longint'($signed(a)) + longint'($signed(b))
                         : longint'($signed(a)) - longint'($signed(b));
        e.f = s[31:0];
        e.of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd6: e.f = (a < b) ? 32'd1 : 32'd0;
      default: e.f = (a < 32) ? (b << a) : 32'd0;
    endcase
    e.zf = (e.f == 0);
    return e;
  endfunction
  function automatic logic [31:0] rnd32();
    case ($urandom % 4)
      0: return $urandom;
      1: return $urandom % 40;
      2: return ($urandom % 2) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: return 32'hFFFF_FFFF - ($urandom % 3);
    endcase
  endfunction
  task automatic drive();
    r0_valid = sv[0]; r0_op = sop[0]; r0_a = sa[0]; r0_b = sb[0];
    r1_valid = sv[1]; r1_op = sop[1]; r1_a = sa[1]; r1_b = sb[1];
  endtask
  task automatic issue(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    sv[r] = 1; so[r] = 0; sop[r] = op; sa[r] = a; sb[r] = b;
  endtask
  task automatic issue_x(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] f, input logic zf, input logic of);
    issue(r, op, a, b);
    so[r] = 1; sx[r].f = f; sx[r].zf = zf; sx[r].of = of;
  endtask
  // One clock: drive slots, observe grants on the falling edge, predict the winner.
  task automatic cycle();
    int w;
    exp_t e;
    drive();
    @(negedge clk);
    if (rst_n && (r0_ready || r1_ready)) begin
      if (!sv[0] && !sv[1]) check("spurious_grant", {r1_ready, r0_ready}, 2'b00);
      else begin
        w = (sv[0] && sv[1]) ? (RR ? int'(ptr_m) : 0) : (sv[1] ? 1 : 0);
        check("grant", {r1_ready, r0_ready}, (w == 1) ? 2'b10 : 2'b01);
        e = so[w] ? sx[w] : model(sop[w], sa[w], sb[w]);
        e.id = w[0];
        e.acc = cyc;
        q.push_back(e);
        grants.push_back(w);
        sv[w] = 0;
        so[w] = 0;
        if (RR) ptr_m = (w == 0);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      cycle();
      if (!sv[0] && !sv[1] && q.size() == 0) return;
    end
    check("drain_timeout", 1, 0);
  endtask
  task automatic wait_valid(input int max);
    for (int i = 0; i < max; i++) begin
      cycle();
      if (res_valid) return;
    end
    check("res_valid_timeout", 0, 1);
  endtask
  task automatic pulse_reset();
    rst_n = 0;
    q.delete();
    grants.delete();
    cnt_m = '0;
    ptr_m = 1'b0;
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_op_cnt", op_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  // Monitor: compares every held result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (q.size() == 0) check("unexpected_result", 1, 0);
      else begin
        if (!prev_v) check("latency", cyc - q[0].acc, 2);
        check("result", {res_f, res_zf, res_of, res_id}, {q[0].f, q[0].zf, q[0].of, q[0].id});
        check("ready_in_done", {r1_ready, r0_ready}, 2'b00);
        if (res_ready) begin
          check("op_cnt", op_cnt, cnt_m);
          void'(q.pop_front());
          cnt_m = cnt_m + 1'b1;
        end
      end
    end
    prev_v = res_valid;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [CW-1:0] c0;
    int n;
    for (int r = 0; r < 2; r++) begin
      sv[r] = 0; so[r] = 0; sop[r] = 0; sa[r] = 0; sb[r] = 0;
      sx[r].f = 0; sx[r].zf = 0; sx[r].of = 0; sx[r].id = 0; sx[r].acc = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {res_valid, res_f, res_zf, res_of, res_id, busy, op_cnt, r0_ready, r1_ready}, '0);
    rst_n = 1;
    @(posedge clk);
    #1;
    res_ready = 1;
    issue_x(0, 3'd4, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1);
    drain(20);
    issue_x(1, 3'd5, 32'h8000_0000, 32'h8000_0000, 32'h0, 1, 0);
    drain(20);
    issue_x(1, 3'd7, 32'h4, 32'h3, 32'h30, 0, 0);
    drain(20);
    issue_x(1, 3'd7, 32'h40, 32'h3, 32'h0, 1, 0);
    drain(20);
    issue_x(0, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
    issue_x(1, 3'd6, 32'h1, 32'hFFFF_FFFF, 32'h1, 0, 0);
    drain(20);
    // Result held with consumer stalled; a competing request must not be accepted.
    res_ready = 0;
    issue(0, 3'd2, rnd32(), rnd32());
    wait_valid(20);
    issue(1, 3'd0, rnd32(), rnd32());
    repeat (10) cycle();
    c0 = op_cnt;
    res_ready = 1;
    cycle();
    check("op_cnt_release", op_cnt, c0 + 1'b1);
    cycle();
    check("op_cnt_once", op_cnt, c0 + 1'b1);
    drain(20);
    // Reset while a result is held.
    res_ready = 0;
    issue(0, 3'd4, 32'd5, 32'd6);
    wait_valid(20);
    issue(0, 3'd4, 32'd5, 32'd6);
    issue(1, 3'd1, rnd32(), rnd32());
    pulse_reset();
    res_ready = 1;
    n = 0;
    while (grants.size() < 4 && n < 40) begin
      if (!sv[0]) issue(0, 3'($urandom), rnd32(), rnd32());
      if (!sv[1]) issue(1, 3'($urandom), rnd32(), rnd32());
      cycle();
      n++;
    end
    for (int i = 0; i < 4; i++)
      check("grant_seq", (i < grants.size()) ? grants[i] : -1, RR ? (i % 2) : 0);
    drain(100);
    // Sixteen results from reset wrap the 4-bit counter back to zero.
    pulse_reset();
    n = 0;
    for (int i = 0; i < 200 && n < 16; i++) begin
      if (!sv[i % 2]) begin
        issue(i % 2, 3'($urandom), rnd32(), rnd32());
        n++;
      end
      cycle();
    end
    drain(100);
    check("op_cnt_wrap", op_cnt, 0);
    // Randomized traffic with stalls, withdrawals and operand churn.
    for (int i = 0; i < 800; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!sv[r] && ($urandom % 3 == 0)) issue(r, 3'($urandom), rnd32(), rnd32());
        else if (sv[r] && ($urandom % 16 == 0)) sv[r] = 0;
        else if (sv[r] && ($urandom % 4 == 0)) begin
          sa[r] = rnd32();
          sop[r] = 3'($urandom);
        end
      end
      res_ready = ($urandom % 4) != 0;
      cycle();
    end
    res_ready = 1;
    drain(100);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
